// File: rtl/servo_setpoint_ramp.sv
// -----------------------------------------------------------------------------
// servo_setpoint_ramp
//
// Turns raw joystick axis samples into a slew-limited servo pulse width.
// A sample is clamped to the calibrated joystick range and snapped to the
// centre value inside a small deadzone. It is then scaled to microseconds by
// an exact 21-step restoring divider. The resulting target is followed by
// 'control', which moves at most STEP_MAX once per servo frame.
//
// Ports:
//   CLK           system clock
//   RST_N         asynchronous active-low reset
//   sample_valid  raw sample present (handshake with sample_ready)
//   sample_ready  high while idle, low while a sample is being converted
//   sample        raw joystick axis value, unsigned 32 bits
//   enable        allows the slew stage to move control on frame ticks
//   control       pulse width in us driven to the servo PWM generator
//   target        most recent scaled set-point in us
//   target_valid  one-cycle pulse in the cycle target takes a new value
//   at_target     control equals target
// -----------------------------------------------------------------------------
module servo_setpoint_ramp #(
  parameter int unsigned IN_MIN       = 32'd228,
  parameter int unsigned IN_MAX       = 32'd830,
  parameter int unsigned CENTER       = 32'd529,
  parameter int unsigned DEADZONE     = 32'd8,
  parameter int unsigned OUT_MIN      = 32'd650,
  parameter int unsigned OUT_MAX      = 32'd2600,
  parameter int unsigned STEP_MAX     = 32'd40,
  parameter int unsigned FRAME_CYCLES = 32'd500000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [31:0] sample,
  input  logic        enable,
  output logic [31:0] control,
  output logic [31:0] target,
  output logic        target_valid,
  output logic        at_target
);

  localparam int NUM_W = 21;
  localparam int CNT_W = (FRAME_CYCLES > 32'd1) ? $clog2(FRAME_CYCLES) : 1;

  localparam logic [31:0]      IN_MIN_W   = IN_MIN;
  localparam logic [31:0]      IN_MAX_W   = IN_MAX;
  localparam logic [31:0]      CENTER_W   = CENTER;
  localparam logic [31:0]      DZ_LO      = 32'(CENTER - DEADZONE);
  localparam logic [31:0]      DZ_HI      = 32'(CENTER + DEADZONE);
  localparam logic [31:0]      OUT_MIN_W  = OUT_MIN;
  localparam logic [31:0]      MID_W      = 32'((OUT_MIN + OUT_MAX) / 32'd2);
  localparam logic [31:0]      STEP_W     = STEP_MAX;
  localparam logic [NUM_W-1:0] OUT_SPAN_N = NUM_W'(OUT_MAX - OUT_MIN);
  localparam logic [11:0]      DIVISOR    = 12'(IN_MAX - IN_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_CYCLES - 32'd1);
  localparam logic [4:0]       LAST_ITER  = 5'(NUM_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLAMP = 2'd1,
    DIV   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      sample_r;
  logic [NUM_W-1:0] num_r;       // numerator, shifted out MSB first; fills with quotient bits
  logic [10:0]      rem_r;
  logic [4:0]       iter_r;
  logic [31:0]      target_r;
  logic [31:0]      slew_tgt_r;  // target as seen by the slew stage, one cycle behind
  logic [31:0]      control_r;
  logic             target_valid_r;
  logic             sample_ready_r;
  logic [CNT_W-1:0] cnt_r;

  logic             handshake_s;
  logic [31:0]      clamp_s;
  logic [31:0]      dz_s;
  logic [31:0]      offset_s;
  logic [11:0]      rem_shift_s;
  logic             ge_s;
  logic [NUM_W-1:0] quo_next_s;
  logic             tick_s;
  logic [31:0]      up_diff_s;
  logic [31:0]      dn_diff_s;
  logic [31:0]      control_nxt_s;

  assign handshake_s = sample_valid && sample_ready_r;

  // Clamp the raw sample to the calibrated range, then snap the deadzone to centre.
  always_comb begin
    clamp_s = sample_r;
    dz_s    = sample_r;
    if (sample_r < IN_MIN_W) begin
      clamp_s = IN_MIN_W;
    end else if (sample_r > IN_MAX_W) begin
      clamp_s = IN_MAX_W;
    end else begin
      clamp_s = sample_r;
    end
    if ((clamp_s >= DZ_LO) && (clamp_s <= DZ_HI)) begin
      dz_s = CENTER_W;
    end else begin
      dz_s = clamp_s;
    end
  end

  assign offset_s = dz_s - IN_MIN_W;

  // One restoring-division step: shift in the next numerator bit, subtract if it fits.
  assign rem_shift_s = {rem_r, num_r[NUM_W-1]};
  assign ge_s        = (rem_shift_s >= DIVISOR);
  assign quo_next_s  = {num_r[NUM_W-2:0], ge_s};

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          state_nxt_s = CLAMP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLAMP: state_nxt_s = DIV;
      DIV: begin
        if (iter_r == LAST_ITER) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = DIV;
        end
      end
      WRITE:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sample capture, scaling datapath, divider and target register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sample_r       <= 32'd0;
      num_r          <= {NUM_W{1'b0}};
      rem_r          <= 11'd0;
      iter_r         <= 5'd0;
      target_r       <= MID_W;
      target_valid_r <= 1'b0;
      sample_ready_r <= 1'b1;
    end else begin
      target_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            sample_r       <= sample;
            sample_ready_r <= 1'b0;
          end
        end
        CLAMP: begin
          // Product cannot exceed 602*1950 < 2^21, so the narrow cast is exact.
          num_r  <= NUM_W'(offset_s[NUM_W-1:0] * OUT_SPAN_N);
          rem_r  <= 11'd0;
          iter_r <= 5'd0;
        end
        DIV: begin
          num_r  <= quo_next_s;
          rem_r  <= ge_s ? 11'(rem_shift_s - DIVISOR) : rem_shift_s[10:0];
          iter_r <= iter_r + 5'd1;
          if (iter_r == LAST_ITER) begin
            // The quotient is at most OUT_MAX-OUT_MIN, so 11 bits hold it.
            target_r       <= OUT_MIN_W + 32'(quo_next_s[10:0]);
            target_valid_r <= 1'b1;
          end
        end
        WRITE: begin
          sample_ready_r <= 1'b1;
        end
        default: begin
          sample_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign tick_s = (cnt_r == CNT_LAST);

  // Free-running servo frame counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign up_diff_s = slew_tgt_r - control_r;
  assign dn_diff_s = control_r - slew_tgt_r;

  // Slew-limited step toward the delayed target, never past it.
  always_comb begin
    control_nxt_s = control_r;
    if (tick_s && enable) begin
      if (slew_tgt_r > control_r) begin
        control_nxt_s = control_r + ((up_diff_s > STEP_W) ? STEP_W : up_diff_s);
      end else if (slew_tgt_r < control_r) begin
        control_nxt_s = control_r - ((dn_diff_s > STEP_W) ? STEP_W : dn_diff_s);
      end else begin
        control_nxt_s = control_r;
      end
    end else begin
      control_nxt_s = control_r;
    end
  end

  // Control register plus the one-cycle-delayed target copy. The delay makes a
  // frame tick that lands on the target write (or on the WRITE cycle itself)
  // still steer toward the previous target.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      control_r  <= MID_W;
      slew_tgt_r <= MID_W;
    end else begin
      control_r  <= control_nxt_s;
      slew_tgt_r <= target_r;
    end
  end

  assign control      = control_r;
  assign target       = target_r;
  assign target_valid = target_valid_r;
  assign sample_ready = sample_ready_r;
  assign at_target    = (control_r == target_r);

endmodule

// File: tb/tb_servo_setpoint_ramp.sv
// -----------------------------------------------------------------------------
// tb_servo_setpoint_ramp
//
// Self-checking bench for servo_setpoint_ramp with a 16-cycle servo frame.
// Expected targets come from an arithmetic model of clamp/deadzone/scale and
// are queued when a sample is offered, then popped when target_valid appears.
// -----------------------------------------------------------------------------
module tb_servo_setpoint_ramp;

  localparam int FRAME = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [31:0] sample = 32'd0;
  logic        enable = 1'b0;
  logic [31:0] control;
  logic [31:0] target;
  logic        target_valid;
  logic        at_target;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  int   bcnt;
  logic ticked;

  servo_setpoint_ramp #(.FRAME_CYCLES(FRAME)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample       (sample),
    .enable       (enable),
    .control      (control),
    .target       (target),
    .target_valid (target_valid),
    .at_target    (at_target)
  );

  // 100 MHz bench clock.
  always #5 CLK = ~CLK;

  // Frame phase tracker: 'ticked' is high for the cycle after a frame wrap edge.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bcnt   <= 0;
      ticked <= 1'b0;
    end else begin
      ticked <= (bcnt == FRAME - 1);
      bcnt   <= (bcnt == FRAME - 1) ? 0 : bcnt + 1;
    end
  end

  function automatic int exp_target(input logic [31:0] s);
    longint x;
    longint d;
    x = {32'd0, s};
    if (x < 228) x = 228;
    else if (x > 830) x = 830;
    d = x - 529;
    if (d < 0) d = -d;
    if (d <= 8) x = 529;
    return int'(650 + ((x - 228) * 1950) / 602);
  endfunction

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!ticked && n < 4 * FRAME);
    n_cmp++;
    if (!ticked) begin
      n_err++;
      $display("FAIL tick_timeout: no frame tick within %0d cycles", n);
    end
  endtask

  task automatic send_sample(input logic [31:0] s);
    int got;
    int bad_rdy;
    int e;
    got = 0;
    do begin
      @(negedge CLK);
      got++;
    end while (!sample_ready && got < 100);
    sample       = s;
    sample_valid = 1'b1;
    exp_q.push_back(exp_target(s));
    @(posedge CLK);
    #1 sample_valid = 1'b0;
    got     = 0;
    bad_rdy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (sample_ready !== 1'b0) bad_rdy++;
      if (target_valid === 1'b1) begin
        got = k;
        break;
      end
    end
    n_cmp++;
    if (bad_rdy != 0)
      begin n_err++; $display("FAIL ready_busy: sample_ready high in %0d busy cycles, required 0", bad_rdy); end
    n_cmp++;
    if (got != 23)
      begin n_err++; $display("FAIL valid_latency: target_valid at cycle %0d, required 23", got); end
    if (got != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (target !== 32'(e))
        begin n_err++; $display("FAIL target(%0d): got %0d, required %0d", s, target, e); end
    end else begin
      exp_q.delete();
    end
    @(negedge CLK);
    n_cmp++;
    if (target_valid !== 1'b0 || sample_ready !== 1'b1)
      begin n_err++; $display("FAIL pulse_end: target_valid=%b sample_ready=%b, required 0/1", target_valid, sample_ready); end
  endtask

  task automatic test_reset();
    int pulses;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (control !== 32'd1625 || target !== 32'd1625 || sample_ready !== 1'b1 || at_target !== 1'b1 || target_valid !== 1'b0)
      begin n_err++; $display("FAIL reset_hold: ctl=%0d tgt=%0d rdy=%b at=%b tv=%b, required 1625/1625/1/1/0", control, target, sample_ready, at_target, target_valid); end
    RST_N = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge CLK);
      if (target_valid !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses != 0)
      begin n_err++; $display("FAIL reset_no_valid: %0d target_valid pulses, required 0", pulses); end
    n_cmp++;
    if (control !== 32'd1625 || target !== 32'd1625 || sample_ready !== 1'b1 || at_target !== 1'b1)
      begin n_err++; $display("FAIL reset_release: ctl=%0d tgt=%0d rdy=%b at=%b, required 1625/1625/1/1", control, target, sample_ready, at_target); end
  endtask

  task automatic test_hold_then_ramp();
    enable = 1'b0;
    send_sample(32'd830);
    for (int t = 0; t < 5; t++) begin
      wait_tick();
      n_cmp++;
      if (control !== 32'd1625 || at_target !== 1'b0)
        begin n_err++; $display("FAIL hold_tick%0d: ctl=%0d at=%b, required 1625/0", t, control, at_target); end
    end
    enable = 1'b1;
    wait_tick();
    n_cmp++;
    if (control !== 32'd1665)
      begin n_err++; $display("FAIL ramp_first: ctl=%0d, required 1665", control); end
    repeat (23) wait_tick();
    n_cmp++;
    if (control !== 32'd2585)
      begin n_err++; $display("FAIL ramp_24th: ctl=%0d, required 2585", control); end
    wait_tick();
    n_cmp++;
    if (control !== 32'd2600 || at_target !== 1'b1)
      begin n_err++; $display("FAIL ramp_last: ctl=%0d at=%b, required 2600/1", control, at_target); end
    wait_tick();
    n_cmp++;
    if (control !== 32'd2600)
      begin n_err++; $display("FAIL no_overshoot: ctl=%0d, required 2600", control); end
  endtask

  task automatic test_clamp();
    enable = 1'b0;
    send_sample(32'd100);
    send_sample(32'hFFFF_FFFF);
    send_sample(32'd228);
    n_cmp++;
    if (control !== 32'd2600)
      begin n_err++; $display("FAIL clamp_ctl_hold: ctl=%0d, required 2600", control); end
  endtask

  task automatic test_deadzone();
    send_sample(32'd535);
    send_sample(32'd538);
    send_sample(32'd520);
    send_sample(32'd537);
    send_sample(32'd521);
  endtask

  task automatic test_write_on_tick();
    enable = 1'b0;
    send_sample(32'd0);
    enable = 1'b1;
    wait_tick();
    n_cmp++;
    if (control !== 32'd2560)
      begin n_err++; $display("FAIL enable_step: ctl=%0d, required 2560", control); end
    // Offer the next sample so that its target write lands on a frame tick.
    repeat (8) @(negedge CLK);
    send_sample(32'd830);
    n_cmp++;
    if (control !== 32'd2480 || target !== 32'd2600)
      begin n_err++; $display("FAIL write_on_tick: ctl=%0d tgt=%0d, required 2480/2600", control, target); end
    wait_tick();
    n_cmp++;
    if (control !== 32'd2520)
      begin n_err++; $display("FAIL after_write_tick: ctl=%0d, required 2520", control); end
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!sample_ready && n < 100);
    sample       = 32'd830;
    sample_valid = 1'b1;
    exp_q.push_back(exp_target(32'd830));
    @(posedge CLK);
    #1 sample_valid = 1'b0;
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (sample_ready !== 1'b0 || target_valid !== 1'b0)
      begin n_err++; $display("FAIL mid_div_busy: rdy=%b tv=%b, required 0/0", sample_ready, target_valid); end
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (control !== 32'd1625 || target !== 32'd1625 || target_valid !== 1'b0 || sample_ready !== 1'b1)
      begin n_err++; $display("FAIL mid_div_reset: ctl=%0d tgt=%0d tv=%b rdy=%b, required 1625/1625/0/1", control, target, target_valid, sample_ready); end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (sample_ready !== 1'b1)
      begin n_err++; $display("FAIL ready_after_release: rdy=%b, required 1", sample_ready); end
    pulses = 0;
    repeat (30) begin
      @(negedge CLK);
      if (target_valid !== 1'b0 || target !== 32'd1625) pulses++;
    end
    n_cmp++;
    if (pulses != 0)
      begin n_err++; $display("FAIL aborted_div: %0d cycles with pulse or target change, required 0", pulses); end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_hold_then_ramp();
    test_clamp();
    test_deadzone();
    test_write_on_tick();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
